// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction cache: machine width, default geometry
// and the cache controller state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int DEFAULT_INDEX_WIDTH = 6;

  typedef logic [1:0] ic_state_t;

  localparam ic_state_t ST_IDLE    = 2'd0;
  localparam ic_state_t ST_ISSUE   = 2'd1;
  localparam ic_state_t ST_WAIT    = 2'd2;
  localparam ic_state_t ST_DISCARD = 2'd3;

endpackage

// File: rtl/icache_array.sv
// Storage for the direct-mapped instruction cache: data and tag arrays without
// reset, plus a per-line valid vector that is cleared by reset.
module icache_array
  import riscv_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  input  logic [TAG_WIDTH-1:0]   rd_tag,
  output logic                   rd_hit,
  output logic [XLEN-1:0]        rd_data,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [XLEN-1:0]        wr_data
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [XLEN-1:0]      data_arr [LINES];
  logic [TAG_WIDTH-1:0] tag_arr  [LINES];
  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     valid_d;

  // Next valid vector: a fill marks its line valid; nothing ever invalidates.
  always_comb begin
    valid_d = valid_q;
    if (we) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  // Valid bits are the only storage that reset clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Line fill: data and tag written together; contents are meaningless until valid.
  always_ff @(posedge clk) begin
    if (we) begin
      data_arr[wr_index] <= wr_data;
      tag_arr[wr_index]  <= wr_tag;
    end
  end

  assign rd_hit  = valid_q[rd_index] && (tag_arr[rd_index] == rd_tag);
  assign rd_data = data_arr[rd_index];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Hits answer one cycle after the request; misses issue a single word fetch to
// the memory controller, fill the line and forward the word. A flush abandons
// the current request; a fetch already in flight is absorbed into the array.
module icache_direct
  import riscv_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            flush,
  output logic            fetch_ins_valid,
  output logic [XLEN-1:0] fetch_ins,
  input  logic            mc_enable,
  input  logic [XLEN-1:0] mc_ins,
  input  logic            mc_ins_rdy,
  output logic            mc_req,
  output logic [XLEN-1:0] mc_addr
);

  ic_state_t       state_q, state_d;
  logic            fetch_ins_valid_q, fetch_ins_valid_d;
  logic [XLEN-1:0] fetch_ins_q, fetch_ins_d;
  logic            mc_req_q, mc_req_d;
  logic [XLEN-1:0] mc_addr_q, mc_addr_d;

  logic            arr_we;
  logic            rd_hit;
  logic [XLEN-1:0] rd_data;

  // Byte offset within the word plays no part in lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc[1:0];

  // Lookup uses the live request pc; fills use the latched miss address.
  icache_array #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_index(fetch_pc[INDEX_WIDTH+1:2]),
    .rd_tag  (fetch_pc[XLEN-1:INDEX_WIDTH+2]),
    .rd_hit  (rd_hit),
    .rd_data (rd_data),
    .we      (arr_we),
    .wr_index(mc_addr_q[INDEX_WIDTH+1:2]),
    .wr_tag  (mc_addr_q[XLEN-1:INDEX_WIDTH+2]),
    .wr_data (mc_ins)
  );

  // Controller next state: everything holds while rdy is low; otherwise the
  // response and request strobes default to idle and the FSM advances.
  always_comb begin
    state_d           = state_q;
    fetch_ins_valid_d = fetch_ins_valid_q;
    fetch_ins_d       = fetch_ins_q;
    mc_req_d          = mc_req_q;
    mc_addr_d         = mc_addr_q;
    arr_we            = 1'b0;
    if (rdy) begin
      fetch_ins_valid_d = 1'b0;
      mc_req_d          = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fetch_valid && !flush) begin
            if (rd_hit) begin
              fetch_ins_valid_d = 1'b1;
              fetch_ins_d       = rd_data;
            end else begin
              mc_addr_d = {fetch_pc[XLEN-1:2], 2'b00};
              state_d   = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (flush) begin
            state_d = ST_IDLE;
          end else if (mc_enable) begin
            mc_req_d = 1'b1;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mc_ins_rdy) begin
            // The returned word is always correct for mc_addr, so fill even
            // when the requester has just redirected.
            arr_we  = 1'b1;
            state_d = ST_IDLE;
            if (!flush) begin
              fetch_ins_valid_d = 1'b1;
              fetch_ins_d       = mc_ins;
            end
          end else if (flush) begin
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (mc_ins_rdy) begin
            arr_we  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      fetch_ins_valid_q <= 1'b0;
      fetch_ins_q       <= '0;
      mc_req_q          <= 1'b0;
      mc_addr_q         <= '0;
    end else begin
      state_q           <= state_d;
      fetch_ins_valid_q <= fetch_ins_valid_d;
      fetch_ins_q       <= fetch_ins_d;
      mc_req_q          <= mc_req_d;
      mc_addr_q         <= mc_addr_d;
    end
  end

  assign fetch_ins_valid = fetch_ins_valid_q;
  assign fetch_ins       = fetch_ins_q;
  assign mc_req          = mc_req_q;
  assign mc_addr         = mc_addr_q;

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: reset, cold miss/hit, conflict eviction,
// controller back-pressure, flush handling and rdy stalls.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        fetch_ins_valid;
  logic [31:0] fetch_ins;
  logic        mc_enable;
  logic [31:0] mc_ins;
  logic        mc_ins_rdy;
  logic        mc_req;
  logic [31:0] mc_addr;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   req_rises = 0;
  int   rets      = 0;
  logic mc_req_prev = 1'b0;

  always #5 clk = ~clk;

  icache_direct dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .flush          (flush),
    .fetch_ins_valid(fetch_ins_valid),
    .fetch_ins      (fetch_ins),
    .mc_enable      (mc_enable),
    .mc_ins         (mc_ins),
    .mc_ins_rdy     (mc_ins_rdy),
    .mc_req         (mc_req),
    .mc_addr        (mc_addr)
  );

  // Count issued memory requests (rising edges of mc_req).
  always @(negedge clk) begin
    if (mc_req === 1'b1 && mc_req_prev !== 1'b1) req_rises++;
    mc_req_prev = mc_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory return: only legal with exactly one request outstanding.
  task automatic mem_ret(input logic [31:0] d);
    @(negedge clk);
    #1;
    chk("proto_outstanding", req_rises, rets + 1);
    rets++;
    mc_ins_rdy = 1'b1;
    mc_ins     = d;
    tick();
    mc_ins_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0;
    mc_enable = 1'b0; mc_ins = '0; mc_ins_rdy = 1'b0;

    // 1. Reset values, then reset asserted mid-WAIT
    tick(); tick();
    chk("rst_valid", fetch_ins_valid, 0);
    chk("rst_ins", fetch_ins, 0);
    chk("rst_req", mc_req, 0);
    chk("rst_addr", mc_addr, 0);
    rst = 1'b0;
    tick();
    fetch_valid = 1'b1; fetch_pc = 32'h40; mc_enable = 1'b1;
    tick();
    chk("t1_issue_addr", mc_addr, 32'h40);
    chk("t1_issue_req", mc_req, 0);
    tick();
    chk("t1_req", mc_req, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t1_async_req", mc_req, 0);
    chk("t1_async_addr", mc_addr, 0);
    chk("t1_async_valid", fetch_ins_valid, 0);
    rets++;
    rst = 1'b0;
    fetch_pc = 32'h0;
    tick();
    chk("t1_pc0_req0", mc_req, 0);
    tick();
    chk("t1_pc0_req", mc_req, 1);
    chk("t1_pc0_addr", mc_addr, 32'h0);
    mem_ret(32'h0000_0013);
    fetch_valid = 1'b0;
    chk("t1_fill_valid", fetch_ins_valid, 1);
    chk("t1_fill_ins", fetch_ins, 32'h0000_0013);
    tick();
    chk("t1_pulse_end", fetch_ins_valid, 0);

    // 2. Cold miss then hit
    fetch_valid = 1'b1; fetch_pc = 32'h1000;
    tick();
    chk("t2_miss_noreq", mc_req, 0);
    chk("t2_addr", mc_addr, 32'h1000);
    tick();
    chk("t2_req", mc_req, 1);
    tick();
    chk("t2_req_once", mc_req, 0);
    mem_ret(32'h0050_0093);
    fetch_valid = 1'b0;
    chk("t2_fill_valid", fetch_ins_valid, 1);
    chk("t2_fill_ins", fetch_ins, 32'h0050_0093);
    tick();
    chk("t2_pulse_end", fetch_ins_valid, 0);
    fetch_valid = 1'b1; fetch_pc = 32'h1000;
    tick();
    fetch_valid = 1'b0;
    chk("t2_hit_valid", fetch_ins_valid, 1);
    chk("t2_hit_ins", fetch_ins, 32'h0050_0093);
    chk("t2_hit_noreq", mc_req, 0);
    tick();
    chk("t2_hit_end", fetch_ins_valid, 0);
    chk("t2_hit_noreq2", mc_req, 0);

    // 3. Conflict eviction (0x1000 and 0x1100 share index 0)
    fetch_valid = 1'b1; fetch_pc = 32'h1100;
    tick();
    chk("t3_miss_valid", fetch_ins_valid, 0);
    chk("t3_addr", mc_addr, 32'h1100);
    tick();
    chk("t3_req", mc_req, 1);
    mem_ret(32'h00A0_0113);
    fetch_valid = 1'b0;
    chk("t3_fill_ins", fetch_ins, 32'h00A0_0113);
    tick();
    fetch_valid = 1'b1; fetch_pc = 32'h1000;
    tick();
    chk("t3_evicted_valid", fetch_ins_valid, 0);
    chk("t3_evicted_addr", mc_addr, 32'h1000);
    tick();
    chk("t3_evicted_req", mc_req, 1);
    mem_ret(32'h0050_0093);
    fetch_valid = 1'b0;
    chk("t3_refill_ins", fetch_ins, 32'h0050_0093);
    tick();

    // 4. Controller busy; pc[1:0] ignored
    mc_enable = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h2006;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_busy_req", mc_req, 0);
      chk("t4_busy_addr", mc_addr, 32'h2004);
    end
    mc_enable = 1'b1;
    tick();
    chk("t4_req", mc_req, 1);
    chk("t4_req_addr", mc_addr, 32'h2004);
    tick();
    chk("t4_req_once", mc_req, 0);
    mem_ret(32'h1111_1111);
    fetch_valid = 1'b0;
    chk("t4_fill_ins", fetch_ins, 32'h1111_1111);
    tick();
    fetch_valid = 1'b1; fetch_pc = 32'h2007;
    tick();
    fetch_valid = 1'b0;
    chk("t4_hit_valid", fetch_ins_valid, 1);
    chk("t4_hit_ins", fetch_ins, 32'h1111_1111);
    tick();

    // 5. Flush in WAIT, fetch during DISCARD, refetch of flushed address
    fetch_valid = 1'b1; fetch_pc = 32'h3008;
    tick(); tick();
    chk("t5_req", mc_req, 1);
    flush = 1'b1; fetch_valid = 1'b0;
    tick();
    chk("t5_flush_valid", fetch_ins_valid, 0);
    flush = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h1000;
    tick();
    chk("t5_disc_valid1", fetch_ins_valid, 0);
    chk("t5_disc_req", mc_req, 0);
    tick();
    chk("t5_disc_valid2", fetch_ins_valid, 0);
    mem_ret(32'hDEAD_BEEF);
    chk("t5_disc_ret_valid", fetch_ins_valid, 0);
    chk("t5_disc_ret_req", mc_req, 0);
    tick();
    fetch_valid = 1'b0;
    chk("t5_after_valid", fetch_ins_valid, 1);
    chk("t5_after_ins", fetch_ins, 32'h0050_0093);
    fetch_valid = 1'b1; fetch_pc = 32'h3008; flush = 1'b1;
    tick();
    chk("t5_idle_flush_valid", fetch_ins_valid, 0);
    chk("t5_idle_flush_req", mc_req, 0);
    flush = 1'b0;
    tick();
    fetch_valid = 1'b0;
    chk("t5_refetch_valid", fetch_ins_valid, 1);
    chk("t5_refetch_ins", fetch_ins, 32'hDEAD_BEEF);
    tick();

    // 5b. Flush coincident with the return: fill, no pulse
    fetch_valid = 1'b1; fetch_pc = 32'h400C;
    tick(); tick();
    chk("t5b_req", mc_req, 1);
    flush = 1'b1;
    mem_ret(32'hCAFE_F00D);
    flush = 1'b0;
    chk("t5b_no_valid", fetch_ins_valid, 0);
    tick();
    fetch_valid = 1'b0;
    chk("t5b_hit_valid", fetch_ins_valid, 1);
    chk("t5b_hit_ins", fetch_ins, 32'hCAFE_F00D);
    tick();

    // 5c. Flush in ISSUE: no request ever issued
    mc_enable = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h6010;
    tick();
    flush = 1'b1; fetch_valid = 1'b0;
    tick();
    chk("t5c_req0", mc_req, 0);
    flush = 1'b0; mc_enable = 1'b1;
    tick();
    chk("t5c_req1", mc_req, 0);
    tick();
    chk("t5c_req2", mc_req, 0);

    // 6. rdy stall in WAIT, then stall during a response pulse
    fetch_valid = 1'b1; fetch_pc = 32'h7014;
    tick(); tick();
    chk("t6_req", mc_req, 1);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_stall_req", mc_req, 1);
      chk("t6_stall_addr", mc_addr, 32'h7014);
      chk("t6_stall_valid", fetch_ins_valid, 0);
    end
    rdy = 1'b1;
    tick();
    chk("t6_resume_req", mc_req, 0);
    mem_ret(32'h0ABC_DEF0);
    fetch_valid = 1'b0;
    chk("t6_fill_valid", fetch_ins_valid, 1);
    chk("t6_fill_ins", fetch_ins, 32'h0ABC_DEF0);
    rdy = 1'b0;
    tick();
    chk("t6_pulse_frozen", fetch_ins_valid, 1);
    rdy = 1'b1;
    tick();
    chk("t6_pulse_end", fetch_ins_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
